comp_edge_win: RTL and testbench

Windowed, multi-channel successor to the single-cycle edge comparator in the LFSR-comparator learning path. For each of `N_CH` synapse channels it pairs pre-synaptic (`x_edge`) and post-synaptic (`y_edge`) edges that arrive up to `WIN` cycles apart. It classifies each pairing as capture, minus, search or backoff, then emits one registered update per event: the selected probability, the increment/decrement direction and a valid pulse. The LFSR comparator stage downstream consumes these updates.

---
 rtl/comp_edge_win.sv | 91 +++++++++
 tb/tb_comp_edge_win.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/comp_edge_win.sv
// comp_edge_win: per-channel windowed x/y edge pairing into registered probability updates.
// Optional COMP_EDGE_DECAY_EN halves prob for capture/minus events paired late in the window.
module comp_edge_win #(
  parameter int N_CH = 4,
  parameter int PW   = 7,
  parameter int WIN  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  x_edge,
  input  logic [N_CH-1:0]  y_edge,
  input  logic [PW-1:0]    u_capture,
  input  logic [PW-1:0]    u_minus,
  input  logic [PW-1:0]    u_search,
  input  logic [PW-1:0]    u_backoff,
  output logic [N_CH*PW-1:0] prob,
  output logic [N_CH-1:0]  inc,
  output logic [N_CH-1:0]  upd_valid
);
  localparam int CW = $clog2(WIN + 1);
  typedef enum logic [1:0] {IDLE, X_PEND, Y_PEND} state_t;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] sel, p_q;
    logic ev, ev_inc, late, inc_q, v_q;
    logic x, y;
    assign x = x_edge[c];
    assign y = y_edge[c];
`ifdef COMP_EDGE_DECAY_EN
    // elapsed distance k = WIN - cnt + 1 while pending
    assign late = (state != IDLE) && ((WIN - int'(cnt) + 1) > WIN / 2);
`else
    assign late = 1'b0;
`endif
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ev      = 1'b0;
      ev_inc  = 1'b0;
      sel     = u_capture;
      case (state)
        IDLE: begin
          ev      = x & y;
          ev_inc  = 1'b1;
          state_n = (x ^ y) ? (x ? X_PEND : Y_PEND) : IDLE;
          cnt_n   = (x ^ y) ? CW'(WIN) : '0;
        end
        X_PEND: begin
          ev      = x | y | (cnt == CW'(1));
          ev_inc  = y;
          sel     = y ? u_capture : u_backoff;
          state_n = x ? X_PEND : (y || cnt == CW'(1)) ? IDLE : X_PEND;
          cnt_n   = x ? CW'(WIN) : (y || cnt == CW'(1)) ? '0 : cnt - CW'(1);
        end
        Y_PEND: begin
          ev      = x | y | (cnt == CW'(1));
          ev_inc  = ~x;
          sel     = x ? u_minus : u_search;
          state_n = y ? Y_PEND : (x || cnt == CW'(1)) ? IDLE : Y_PEND;
          cnt_n   = y ? CW'(WIN) : (x || cnt == CW'(1)) ? '0 : cnt - CW'(1);
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        p_q   <= '0;
        inc_q <= 1'b0;
        v_q   <= 1'b0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        v_q   <= ev;
        if (ev) begin
          // late-paired capture/minus decay; search/backoff never qualify
          p_q   <= (late && ((state == X_PEND && y) || (state == Y_PEND && x))) ? (sel >> 1) : sel;
          inc_q <= ev_inc;
        end
      end
    end
    assign prob[c*PW +: PW] = p_q;
    assign inc[c]           = inc_q;
    assign upd_valid[c]     = v_q;
  end
endmodule

// File: tb/tb_comp_edge_win.sv
// tb_comp_edge_win: directed checks of pairing, timeouts, decay boundary and async reset.
module tb_comp_edge_win;
  localparam int N_CH = 4, PW = 7, WIN = 8;
`ifdef COMP_EDGE_DECAY_EN
  localparam int DEC = 1;
`else
  localparam int DEC = 0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N_CH-1:0] x_edge, y_edge;
  logic [PW-1:0] u_capture, u_minus, u_search, u_backoff;
  logic [N_CH*PW-1:0] prob;
  logic [N_CH-1:0] inc, upd_valid;
  int errors = 0;
  int checks = 0;

  comp_edge_win #(.N_CH(N_CH), .PW(PW), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .x_edge(x_edge), .y_edge(y_edge),
    .u_capture(u_capture), .u_minus(u_minus), .u_search(u_search), .u_backoff(u_backoff),
    .prob(prob), .inc(inc), .upd_valid(upd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [N_CH-1:0] xv, input logic [N_CH-1:0] yv);
    x_edge = xv;
    y_edge = yv;
    @(posedge clk);
    #1;
    x_edge = '0;
    y_edge = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, '0);
  endtask

  initial begin
    rst = 1'b1;
    x_edge = '0;
    y_edge = '0;
    u_capture = 7'd100;
    u_minus = 7'd64;
    u_search = 7'd21;
    u_backoff = 7'd90;
    @(posedge clk);
    #1;
    chk("rst_prob", 32'(prob), 0);
    chk("rst_inc", 32'(inc), 0);
    chk("rst_valid", 32'(upd_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // capture ch0, k=3
    cyc(4'b0001, 4'b0000);
    chk("cap_x_quiet", 32'(upd_valid), 0);
    idle(2);
    cyc(4'b0000, 4'b0001);
    chk("cap_valid", 32'(upd_valid), 4'b0001);
    chk("cap_prob", 32'(prob), 100);
    chk("cap_inc", 32'(inc), 4'b0001);
    idle(1);
    chk("cap_pulse", 32'(upd_valid), 0);
    chk("cap_hold", 32'(prob[6:0]), 100);
    // minus ch1, k=6
    cyc(4'b0000, 4'b0010);
    idle(5);
    cyc(4'b0010, 4'b0000);
    chk("minus_valid", 32'(upd_valid), 4'b0010);
    chk("minus_prob", 32'(prob[13:7]), 64 >> DEC);
    chk("minus_inc", 32'(inc), 4'b0001);
    chk("minus_ch0_hold", 32'(prob[6:0]), 100);
    // capture at window edge k=8
    cyc(4'b0001, 4'b0000);
    idle(7);
    cyc(4'b0000, 4'b0001);
    chk("cap_k8_valid", 32'(upd_valid), 4'b0001);
    chk("cap_k8_prob", 32'(prob[6:0]), 100 >> DEC);
    // decay boundary: k=4 unaffected, k=5 decayed
    cyc(4'b0001, 4'b0000);
    idle(3);
    cyc(4'b0000, 4'b0001);
    chk("cap_k4_prob", 32'(prob[6:0]), 100);
    cyc(4'b0000, 4'b0010);
    idle(4);
    cyc(4'b0010, 4'b0000);
    chk("minus_k5_valid", 32'(upd_valid), 4'b0010);
    chk("minus_k5_prob", 32'(prob[13:7]), 64 >> DEC);
    // backoff timeout ch2
    cyc(4'b0100, 4'b0000);
    idle(7);
    chk("bo_early", 32'(upd_valid), 0);
    idle(1);
    chk("bo_valid", 32'(upd_valid), 4'b0100);
    chk("bo_prob", 32'(prob[20:14]), 90);
    chk("bo_inc", 32'(inc[2]), 0);
    idle(1);
    chk("bo_pulse", 32'(upd_valid), 0);
    // search timeout ch3
    cyc(4'b0000, 4'b1000);
    idle(7);
    chk("se_early", 32'(upd_valid), 0);
    idle(1);
    chk("se_valid", 32'(upd_valid), 4'b1000);
    chk("se_prob", 32'(prob[27:21]), 21);
    chk("se_inc", 32'(inc[3]), 1);
    // simultaneous x&y in IDLE stays IDLE
    cyc(4'b0001, 4'b0001);
    chk("sim_valid", 32'(upd_valid), 4'b0001);
    chk("sim_prob", 32'(prob[6:0]), 100);
    chk("sim_inc", 32'(inc[0]), 1);
    cyc(4'b0001, 4'b0000);
    chk("sim_idle", 32'(upd_valid), 0);
    cyc(4'b0000, 4'b0001);
    chk("sim_after_cap", 32'(upd_valid), 4'b0001);
    // repeated x: backoff, then new window
    cyc(4'b0010, 4'b0000);
    idle(1);
    cyc(4'b0010, 4'b0000);
    chk("rep_bo_valid", 32'(upd_valid), 4'b0010);
    chk("rep_bo_prob", 32'(prob[13:7]), 90);
    chk("rep_bo_inc", 32'(inc[1]), 0);
    idle(2);
    cyc(4'b0000, 4'b0010);
    chk("rep_cap_valid", 32'(upd_valid), 4'b0010);
    chk("rep_cap_prob", 32'(prob[13:7]), 100);
    chk("rep_cap_inc", 32'(inc[1]), 1);
    // X_PEND x&y: capture plus reopened window
    cyc(4'b0010, 4'b0000);
    cyc(4'b0010, 4'b0010);
    chk("xxy_valid", 32'(upd_valid), 4'b0010);
    idle(1);
    cyc(4'b0000, 4'b0010);
    chk("xxy_reopen", 32'(upd_valid), 4'b0010);
    chk("xxy_prob", 32'(prob[13:7]), 100);
    // Y_PEND repeated y: search, then minus
    cyc(4'b0000, 4'b1000);
    idle(1);
    cyc(4'b0000, 4'b1000);
    chk("rep_se_valid", 32'(upd_valid), 4'b1000);
    chk("rep_se_prob", 32'(prob[27:21]), 21);
    cyc(4'b1000, 4'b0000);
    chk("ymin_valid", 32'(upd_valid), 4'b1000);
    chk("ymin_prob", 32'(prob[27:21]), 64);
    chk("ymin_inc", 32'(inc[3]), 0);
    // Y_PEND x&y: minus plus reopened window
    cyc(4'b0000, 4'b1000);
    cyc(4'b1000, 4'b1000);
    chk("yxy_valid", 32'(upd_valid), 4'b1000);
    cyc(4'b1000, 4'b0000);
    chk("yxy_reopen", 32'(upd_valid), 4'b1000);
    // two channels concurrently
    cyc(4'b0001, 4'b0010);
    idle(1);
    cyc(4'b0010, 4'b0001);
    chk("multi_valid", 32'(upd_valid), 4'b0011);
    chk("multi_p0", 32'(prob[6:0]), 100);
    chk("multi_p1", 32'(prob[13:7]), 64);
    chk("multi_inc", 32'(inc[1:0]), 2'b01);
    // reset mid-window discards pending x
    cyc(4'b0100, 4'b0000);
    idle(2);
    rst = 1'b1;
    #1;
    chk("arst_prob", 32'(prob), 0);
    chk("arst_inc", 32'(inc), 0);
    chk("arst_valid", 32'(upd_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    cyc(4'b0000, 4'b0100);
    chk("arst_no_upd", 32'(upd_valid), 0);
    idle(7);
    chk("arst_win_quiet", 32'(upd_valid), 0);
    idle(1);
    chk("arst_se_valid", 32'(upd_valid), 4'b0100);
    chk("arst_se_prob", 32'(prob[20:14]), 21);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
